// File: rtl/iter_divider_pkg.sv
// Shared CPU definitions: data type, divider FSM states and counter width.
package cpuDefine;

    typedef logic [31:0] DType;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } DivState;

endpackage

// File: rtl/iter_divider_if.sv
// Request/result bundle between the execute-stage ALU and the iterative divider.
interface iter_divider_if #(
    parameter int WIDTH = 32
);
    logic             en;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             complete;

    modport master (
        output en, is_signed, dividend, divisor,
        input  quotient, remainder, complete
    );

    modport slave (
        input  en, is_signed, dividend, divisor,
        output quotient, remainder, complete
    );
endinterface

// File: rtl/iter_divider_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             next_bit,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    // rem < dvs always holds, so diff fits WIDTH+1 bits and its MSB is the borrow.
    always_comb begin
        trial = {rem, next_bit};
        diff  = trial - {1'b0, dvs};
        q_bit = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end
endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, sign fixed at the end.
module iter_divider
    import cpuDefine::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    iter_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    DivState state, next_state;

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] prem;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dvs_mag;
    logic             sgn_q;
    logic             sgn_r;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             start;
    logic             step;
    logic             last;
    logic             div_zero;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic use_sign);
        return (use_sign && v[WIDTH-1]) ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        return neg ? (~mag + 1'b1) : mag;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (prem),
        .next_bit (acc[WIDTH-1]),
        .dvs      (dvs_mag),
        .rem_out  (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        step       = 1'b0;
        last       = 1'b0;
        div_zero   = (bus.divisor == '0);
        unique case (state)
            IDLE: begin
                if (bus.en) begin
                    start      = 1'b1;
                    next_state = div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                if (!bus.en) begin
                    next_state = IDLE;
                end else begin
                    step = 1'b1;
                    if (cnt == '0) begin
                        last       = 1'b1;
                        next_state = DONE;
                    end
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign bus.complete = (state == DONE);

    // The dividend magnitude shifts out of acc MSB-first while quotient bits shift in.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt           <= '0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
        end else if (start) begin
            sgn_q   <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
            sgn_r   <= bus.is_signed & bus.dividend[WIDTH-1];
            acc     <= magnitude(bus.dividend, bus.is_signed);
            dvs_mag <= magnitude(bus.divisor, bus.is_signed);
            prem    <= '0;
            cnt     <= CNT_W'(WIDTH - 1);
            if (div_zero) begin
                bus.quotient  <= '1;
                bus.remainder <= bus.dividend;
            end
        end else if (step) begin
            prem <= step_rem;
            acc  <= {acc[WIDTH-2:0], step_q};
            cnt  <= cnt - 1'b1;
            if (last) begin
                bus.quotient  <= apply_sign({acc[WIDTH-2:0], step_q}, sgn_q);
                bus.remainder <= apply_sign(step_rem, sgn_r);
            end
        end
    end
endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle 32-bit integer divider that serves the execute-stage ALU's divide and modulo requests: signed/unsigned DIV, DIVU, MOD and MODU. The ALU holds `en` high with stable operands and stalls its pipeline stage until `complete` pulses. The block then returns quotient and remainder together. It uses a radix-2 restoring algorithm on operand magnitudes, resolving one quotient bit per cycle, with sign correction at the end.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `en` input 1: request level. It is held high by the requester until `complete` is seen. Dropping it aborts the operation.
- `is_signed` input 1: 1 selects two's-complement operation, 0 selects unsigned. Sampled at start.
- `dividend` input WIDTH: sampled at start.
- `divisor` input WIDTH: sampled at start.
- `quotient` output WIDTH: registered result.
- `remainder` output WIDTH: registered result.
- `complete` output 1: result-valid pulse, exactly one cycle per finished operation.

## Operation
- States are IDLE, CALC and DONE. Reset forces IDLE, `complete`=0, `quotient`=0, `remainder`=0 and iteration counter=0.
- **IDLE with `en`=1** (start):
  - latch `is_signed`, the sign of the dividend, and quotient sign = sign(dividend) XOR sign(divisor);
  - latch |dividend| and |divisor|; magnitudes are taken only when `is_signed`=1;
  - clear the partial remainder; set counter=WIDTH-1; go to CALC.
- **CALC**, each cycle:
  - form the trial value = {partial remainder, next dividend MSB};
  - subtract the divisor magnitude (WIDTH+1-bit subtract);
  - if the result is non-negative, keep the difference and shift in quotient bit 1; otherwise keep the trial value and shift in 0;
  - decrement the counter. When the counter is 0, go to DONE.
- **Leaving CALC (last iteration)**: write the sign-corrected `quotient` and `remainder` registers.
  - Quotient is negated if the quotient sign is set.
  - Remainder is negated if the dividend was negative.
  - The remainder sign always follows the dividend (truncating division).
- **DONE**: `complete`=1 for this one cycle. The next state is IDLE unconditionally.
- **Back-to-back**: if `en` is still high in the IDLE cycle after DONE, that cycle is a new start with the current operands.
- **Divide by zero**, detected at start from the raw divisor: skip CALC and go straight to DONE.
  - `quotient`=all ones, `remainder`=dividend, for both signedness modes.
- **Signed overflow** (`0x80000000` / `-1`): `quotient`=`0x80000000`, `remainder`=0. This falls out of the WIDTH-bit wrap; no special case is needed.
- **Abort**: `en`=0 in any CALC cycle returns to IDLE on the next edge.
  - `quotient` and `remainder` are not updated and keep their previous values.
  - `complete` stays 0.
  - If `en`=0 while in DONE, the pulse still occurs.
- Operand or `is_signed` changes after the start cycle are ignored.
- `quotient` and `remainder` hold their values until the next completed operation.

## Timing
- Start is edge-sampled: cycle 0 is the first IDLE cycle with `en`=1.
- CALC occupies cycles 1..WIDTH (1..32).
- DONE is cycle WIDTH+1 (33). `complete`, `quotient` and `remainder` are valid in that cycle.
- Divide by zero: DONE is cycle 1.
- Minimum start-to-start spacing is WIDTH+2 cycles (34). There is one IDLE cycle between operations.
- `complete` is driven purely from state, with no combinational path from `en`.
- `reset` asserted in any state takes priority over everything. The block is in IDLE the next cycle with all outputs zero.

## Structure
- Shared package `cpuDefine`:
  - `DivState` enum (IDLE/CALC/DONE);
  - `DIV_CNT_W` = $clog2(WIDTH);
  - existing `DType` for 32-bit data.
- One combinational sub-module, `div_step`: one restoring iteration. Inputs are the partial remainder, the next bit and the divisor magnitude. Outputs are the new partial remainder and the quotient bit.
- The FSM, counter, magnitude logic and sign fix stay in this top.

## Test plan
- Unsigned 100 / 7 (`is_signed`=0) -> `complete` at cycle 33, `quotient`=14, `remainder`=2. `complete` is low before and after.
- Signed -7 / 2 -> `quotient`=`0xFFFFFFFD`, `remainder`=`0xFFFFFFFF`.
- Signed 7 / -2 -> `quotient`=`0xFFFFFFFD`, `remainder`=1.
- Signed `0x80000000` / `0xFFFFFFFF` -> `quotient`=`0x80000000`, `remainder`=0.
- The same operands unsigned -> `quotient`=0, `remainder`=`0x80000000`.
- Divide by zero, dividend `0x1234` -> `complete` at cycle 1, `quotient`=`0xFFFFFFFF`, `remainder`=`0x1234`.
- Abort: start 100 / 7, drop `en` at cycle 10 -> no `complete`, outputs keep their prior values. Then restart 9 / 3 -> `quotient`=3, `remainder`=0 at its cycle 33.
- Back-to-back: keep `en` high across two operations -> two single-cycle `complete` pulses 34 cycles apart.
- Reset asserted at cycle 20 -> IDLE next cycle, outputs 0, no `complete`.
